// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: merges stall requests into
// the per-register stall vector and sequences (possibly deferred) exception flushes.
module pipeline_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_if,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             stallreq_mem,
    input  logic             excp_valid,
    input  logic [31:0]      excp_pc,
    input  logic             cnt_clr,
    output logic [5:0]       stall_o,
    output logic             flush_o,
    output logic [31:0]      new_pc_o,
    output logic [CNT_W-1:0] stall_cycles_o
);

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        FLUSH
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic              flush_q, flush_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [5:0]        req_stall;

    // Deepest requesting stage wins; it holds itself and everything upstream.
    always_comb begin
        if (stallreq_mem)      req_stall = 6'b011111;
        else if (stallreq_ex)  req_stall = 6'b001111;
        else if (stallreq_id)  req_stall = 6'b000111;
        else if (stallreq_if)  req_stall = 6'b000011;
        else                   req_stall = 6'b000000;
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            IDLE: begin
                if (excp_valid) begin
                    pc_d    = excp_pc;
                    state_d = stallreq_mem ? PEND : FLUSH;
                end
            end
            PEND:    if (!stallreq_mem) state_d = FLUSH;
            FLUSH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        flush_d = (state_d == FLUSH);
    end

    // An exception waiting on MEM keeps MEM and everything upstream frozen.
    always_comb begin
        if (rst) begin
            stall_o = 6'b000000;
        end else begin
            unique case (state_q)
                IDLE:    stall_o = req_stall;
                PEND:    stall_o = 6'b011111;
                default: stall_o = 6'b000000;
            endcase
        end
    end

    always_comb begin
        if (cnt_clr)                        cnt_d = '0;
        else if (stall_o[0] && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        else                                cnt_d = cnt_q;
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
            flush_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            flush_q <= flush_d;
            cnt_q   <= cnt_d;
        end
    end

    assign flush_o        = flush_q & ~rst;
    assign new_pc_o       = pc_q;
    assign stall_cycles_o = cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: table-driven priority vectors plus
// hand-written reset, exception, deferred-exception and counter sequences.
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic        excp_valid;
    logic [31:0] excp_pc;
    logic        cnt_clr;
    logic [5:0]  stall_o, stall4_o;
    logic        flush_o, flush4_o;
    logic [31:0] new_pc_o, new_pc4_o;
    logic [31:0] cnt_o;
    logic [3:0]  cnt4_o;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] pc;
    } exp_t;

    typedef struct {
        logic       s_if, s_id, s_ex, s_mem;
        logic [5:0] stall;
    } vec_t;

    exp_t sb_q[$];

    pipeline_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
        .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
        .excp_valid(excp_valid), .excp_pc(excp_pc), .cnt_clr(cnt_clr),
        .stall_o(stall_o), .flush_o(flush_o), .new_pc_o(new_pc_o),
        .stall_cycles_o(cnt_o)
    );

    pipeline_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
        .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
        .excp_valid(excp_valid), .excp_pc(excp_pc), .cnt_clr(cnt_clr),
        .stall_o(stall4_o), .flush_o(flush4_o), .new_pc_o(new_pc4_o),
        .stall_cycles_o(cnt4_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input logic i, input logic d, input logic e, input logic m);
        stallreq_if  = i;
        stallreq_id  = d;
        stallreq_ex  = e;
        stallreq_mem = m;
    endtask

    task automatic expect_out(input logic [5:0] s, input logic f, input logic [31:0] pc);
        exp_t e;
        e.stall = s;
        e.flush = f;
        e.pc    = pc;
        sb_q.push_back(e);
    endtask

    // Outputs are compared 1 time unit after the negedge at which inputs were driven.
    task automatic compare_out(input string name);
        exp_t e;
        #1;
        if (sb_q.size() == 0) begin
            check({name, " scoreboard empty"}, 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            check({name, " stall"}, 64'(stall_o), 64'(e.stall));
            check({name, " flush"}, 64'(flush_o), 64'(e.flush));
            check({name, " pc"},    64'(new_pc_o), 64'(e.pc));
        end
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'b000011};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 6'b000111};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 6'b001111};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'b011111};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 6'b011111};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 6'b000111};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 6'b001111};

        // Reset held 3 cycles with every input active.
        rst = 1'b1; cnt_clr = 1'b0;
        set_req(1, 1, 1, 1);
        excp_valid = 1'b1; excp_pc = 32'hCAFE_0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            expect_out(6'b000000, 1'b0, 32'h0);
            compare_out("reset");
            check("reset cnt", 64'(cnt_o), 64'd0);
        end
        rst = 1'b0; set_req(0, 0, 0, 0); excp_valid = 1'b0; excp_pc = 32'h0;
        @(negedge clk);
        set_req(1, 0, 0, 0);
        expect_out(6'b000011, 1'b0, 32'h0);
        compare_out("post-reset idle");

        // Request priority encoding.
        foreach (vecs[i]) begin
            @(negedge clk);
            set_req(vecs[i].s_if, vecs[i].s_id, vecs[i].s_ex, vecs[i].s_mem);
            expect_out(vecs[i].stall, 1'b0, 32'h0);
            compare_out($sformatf("prio[%0d]", i));
        end

        // Immediate exception; requests and a second exception during FLUSH are ignored.
        @(negedge clk);
        set_req(0, 0, 0, 0); excp_valid = 1'b1; excp_pc = 32'hBFC0_0380;
        expect_out(6'b000000, 1'b0, 32'h0);
        compare_out("imm raise");
        @(negedge clk);
        set_req(1, 1, 1, 1); excp_valid = 1'b1; excp_pc = 32'h0000_DEAD;
        expect_out(6'b000000, 1'b1, 32'hBFC0_0380);
        compare_out("imm flush");
        @(negedge clk);
        set_req(0, 0, 0, 0); excp_valid = 1'b0;
        expect_out(6'b000000, 1'b0, 32'hBFC0_0380);
        compare_out("imm after");

        // Deferred exception: MEM stalled 4 cycles, EX toggling, a stray excp ignored.
        @(negedge clk);
        set_req(0, 0, 0, 1); excp_valid = 1'b1; excp_pc = 32'h8000_0180;
        expect_out(6'b011111, 1'b0, 32'hBFC0_0380);
        compare_out("defer raise");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_req(0, 0, i[0], 1);
            excp_valid = (i == 1);
            excp_pc    = 32'h0000_1234;
            expect_out(6'b011111, 1'b0, 32'h8000_0180);
            compare_out($sformatf("pend[%0d]", i));
        end
        @(negedge clk);
        set_req(0, 0, 0, 0); excp_valid = 1'b0;
        expect_out(6'b011111, 1'b0, 32'h8000_0180);
        compare_out("pend release");
        @(negedge clk);
        expect_out(6'b000000, 1'b1, 32'h8000_0180);
        compare_out("defer flush");
        @(negedge clk);
        expect_out(6'b000000, 1'b0, 32'h8000_0180);
        compare_out("defer after");

        // Counter: clear, 10 stall cycles, clear-priority, CNT_W=4 saturation.
        @(negedge clk);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        #1;
        check("cnt cleared", 64'(cnt_o), 64'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            stallreq_id = 1'b1;
        end
        @(negedge clk);
        stallreq_id = 1'b0;
        #1;
        check("cnt 10", 64'(cnt_o), 64'd10);
        check("cnt4 10", 64'(cnt4_o), 64'd10);
        @(negedge clk);
        stallreq_id = 1'b1; cnt_clr = 1'b1;
        @(negedge clk);
        stallreq_id = 1'b0; cnt_clr = 1'b0;
        #1;
        check("cnt clr prio", 64'(cnt_o), 64'd0);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            stallreq_id = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("cnt4 sat %0d", i), 64'(cnt4_o), 64'((i > 15) ? 15 : i));
        end
        @(negedge clk);
        stallreq_id = 1'b0;
        #1;
        check("cnt 20", 64'(cnt_o), 64'd20);

        // Reset mid-PEND abandons the exception.
        @(negedge clk);
        set_req(0, 0, 0, 1); excp_valid = 1'b1; excp_pc = 32'h0000_5555;
        expect_out(6'b011111, 1'b0, 32'h8000_0180);
        compare_out("rp raise");
        @(negedge clk);
        excp_valid = 1'b0; rst = 1'b1;
        expect_out(6'b000000, 1'b0, 32'h0000_5555);
        compare_out("rp in reset");
        @(negedge clk);
        rst = 1'b0; set_req(0, 0, 0, 0);
        expect_out(6'b000000, 1'b0, 32'h0);
        compare_out("rp idle");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            expect_out(6'b000000, 1'b0, 32'h0);
            compare_out($sformatf("rp no flush[%0d]", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
